// File: rtl/calc_result_bcd_formatter_if.sv
// Handshake bundle between the signed result source, the BCD formatter and
// the display driver.
//   master : result source / display side (drives in_data, in_valid, out_ready)
//   slave  : calc_result_bcd_formatter
// Signals:
//   in_data   signed W-bit result to format
//   in_valid  in_data valid (a single-cycle done pulse is legal)
//   in_ready  formatter idle and able to accept
//   out_sign  1 = negative result
//   out_bcd   packed BCD magnitude, digit 0 in [3:0]
//   out_valid out_sign/out_bcd valid
//   out_ready display consumed the output
//   overrun   sticky: in_valid seen while in_ready=0
interface calc_result_bcd_formatter_if #(
  parameter int W    = 8,
  parameter int NDIG = 3
);
  logic signed [W-1:0]      in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     out_sign;
  logic        [4*NDIG-1:0] out_bcd;
  logic                     out_valid;
  logic                     out_ready;
  logic                     overrun;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_sign, out_bcd, out_valid, overrun
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_sign, out_bcd, out_valid, overrun
  );
endinterface

// File: rtl/calc_result_bcd_formatter.sv
// Signed result -> sign + packed BCD magnitude formatter.
// Takes a W-bit two's-complement result, splits off the sign, takes the
// magnitude and converts it to NDIG packed BCD digits with a sequential
// double-dabble (one bit per cycle). The result is handed to the display
// driver through a valid/ready handshake.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  calc_result_bcd_formatter_if.slave
//        (in_data/in_valid/in_ready, out_sign/out_bcd/out_valid/out_ready,
//         overrun)
// Parameters:
//   W     result width, W >= 2
//   NDIG  BCD digits, 10^NDIG > 2^(W-1)
// Optional build macro:
//   CALC_BCD_BLANK_EN  leading-zero digits of out_bcd are emitted as 4'hF
//                      (display blank); digit 0 is never blanked.
module calc_result_bcd_formatter #(
  parameter int W    = 8,
  parameter int NDIG = 3
) (
  input logic                           clk,
  input logic                           rst,
  calc_result_bcd_formatter_if.slave    bus
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [W-1:0]  ONE      = W'(1);

  typedef enum logic [1:0] {IDLE, ABS, CONV, DONE} state_t;

  state_t state_q, state_d;

  logic signed [W-1:0]  data_p0;
  logic                 sign_p1;
  logic        [W-1:0]  mag_p1;
  logic        [BW-1:0] bcd_p1;
  logic        [BW-1:0] adj;
  logic        [CW-1:0] cnt;

  // Double-dabble correction: every digit >= 5 gets +3 before the shift.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < NDIG; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef CALC_BCD_BLANK_EN
  // Replace leading zero digits with the blank code, scanning from the top;
  // digit 0 is excluded so a zero result still shows "0".
  function automatic logic [BW-1:0] blank_lz(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    logic          lead;
    r    = b;
    lead = 1'b1;
    for (int i = NDIG - 1; i > 0; i--) begin
      if (lead && (b[4*i +: 4] == 4'd0)) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
    return r;
  endfunction
`endif

  assign adj          = add3(bcd_p1);
  assign bus.in_ready = (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = ABS;
      ABS:  state_d = CONV;
      CONV: if (cnt == CNT_ONE) state_d = DONE;
      DONE: if (bus.out_valid && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: capture the signed result on accept.
  // Stage p1: sign/magnitude split, then W shift steps of double-dabble.
  // Magnitude of -2^(W-1) is 2^(W-1), which still fits W unsigned bits.
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: if (bus.in_valid) data_p0 <= bus.in_data;
      ABS: begin
        sign_p1 <= data_p0[W-1];
        mag_p1  <= data_p0[W-1] ? (~unsigned'(data_p0) + ONE) : unsigned'(data_p0);
        bcd_p1  <= '0;
        cnt     <= CNT_INIT;
      end
      CONV: begin
        bcd_p1 <= {adj[BW-2:0], mag_p1[W-1]};
        mag_p1 <= {mag_p1[W-2:0], 1'b0};
        cnt    <= cnt - CNT_ONE;
      end
      default: ;
    endcase
  end

  // Output register: loaded on the first DONE cycle, held until handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_sign  <= 1'b0;
      bus.out_bcd   <= '0;
    end else if ((state_q == DONE) && !bus.out_valid) begin
      bus.out_valid <= 1'b1;
      bus.out_sign  <= sign_p1;
`ifdef CALC_BCD_BLANK_EN
      bus.out_bcd   <= blank_lz(bcd_p1);
`else
      bus.out_bcd   <= bcd_p1;
`endif
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                  bus.overrun <= 1'b0;
    else if (bus.in_valid && !bus.in_ready)   bus.overrun <= 1'b1;
  end

endmodule

// File: tb/tb_calc_result_bcd_formatter.sv
module tb_calc_result_bcd_formatter;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  calc_result_bcd_formatter_if #(.W(8), .NDIG(3)) bus8 ();
  calc_result_bcd_formatter_if #(.W(4), .NDIG(1)) bus4 ();

  calc_result_bcd_formatter #(.W(8), .NDIG(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  calc_result_bcd_formatter #(.W(4), .NDIG(1)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] pick(input logic [11:0] plain, input logic [11:0] blanked);
`ifdef CALC_BCD_BLANK_EN
    return blanked;
`else
    return plain;
`endif
  endfunction

  // Accept d, wait for out_valid, check latency/busy/result; optional handoff.
  task automatic run8(input string tag, input logic [7:0] d, input logic s,
                      input logic [11:0] b, input bit handoff);
    int lat;
    bit busy;
    bus8.out_ready = handoff;
    bus8.in_data   = d;
    bus8.in_valid  = 1'b1;
    tick;
    bus8.in_valid  = 1'b0;
    lat  = 0;
    busy = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if (bus8.in_ready) busy = 1'b0;
      tick;
      if (bus8.out_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"},  lat, 10);
    check({tag, "_busy"}, {31'd0, busy}, 1);
    check({tag, "_rdy"},  {31'd0, bus8.in_ready}, 0);
    check({tag, "_sign"}, {31'd0, bus8.out_sign}, {31'd0, s});
    check({tag, "_bcd"},  {20'd0, bus8.out_bcd}, {20'd0, b});
    if (handoff) begin
      tick;
      check({tag, "_vld_drop"}, {31'd0, bus8.out_valid}, 0);
      check({tag, "_rdy_back"}, {31'd0, bus8.in_ready}, 1);
    end
  endtask

  task automatic run4(input string tag, input logic [3:0] d, input logic s, input logic [3:0] b);
    int lat;
    bus4.out_ready = 1'b1;
    bus4.in_data   = d;
    bus4.in_valid  = 1'b1;
    tick;
    bus4.in_valid  = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      tick;
      if (bus4.out_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"},  lat, 6);
    check({tag, "_sign"}, {31'd0, bus4.out_sign}, {31'd0, s});
    check({tag, "_bcd"},  {28'd0, bus4.out_bcd}, {28'd0, b});
    tick;
    check({tag, "_vld_drop"}, {31'd0, bus4.out_valid}, 0);
  endtask

  initial begin
    logic [11:0] held;
    rst            = 1'b1;
    bus8.in_data   = '0;
    bus8.in_valid  = 1'b1;
    bus8.out_ready = 1'b0;
    bus4.in_data   = '0;
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b0;
    tick;
    tick;
    bus8.in_valid = 1'b0;
    check("rst_vld",     {31'd0, bus8.out_valid}, 0);
    check("rst_sign",    {31'd0, bus8.out_sign}, 0);
    check("rst_bcd",     {20'd0, bus8.out_bcd}, 0);
    check("rst_overrun", {31'd0, bus8.overrun}, 0);
    check("rst_rdy",     {31'd0, bus8.in_ready}, 1);
    rst = 1'b0;
    tick;

    run8("pos_max", 8'h7F, 1'b0, 12'h127, 1'b1);
    run8("neg_min", 8'h80, 1'b1, 12'h128, 1'b1);
    run8("neg3",    8'hFD, 1'b1, pick(12'h003, 12'hFF3), 1'b1);
    run8("zero",    8'h00, 1'b0, pick(12'h000, 12'hFF0), 1'b1);
    run4("w4_min",  4'h8,  1'b1, 4'h8);
    run4("w4_pos",  4'h3,  1'b0, 4'h3);

    // Stall in DONE with an extra in_valid pulse: output held, overrun set.
    run8("stall", 8'h9C, 1'b1, 12'h100, 1'b0);
    held = bus8.out_bcd;
    for (int i = 0; i < 5; i++) begin
      bus8.in_data  = 8'h05;
      bus8.in_valid = (i == 2);
      tick;
      bus8.in_valid = 1'b0;
      check("stall_vld", {31'd0, bus8.out_valid}, 1);
      check("stall_bcd", {20'd0, bus8.out_bcd}, {20'd0, held});
    end
    check("stall_overrun", {31'd0, bus8.overrun}, 1);
    bus8.out_ready = 1'b1;
    tick;
    check("stall_vld_drop", {31'd0, bus8.out_valid}, 0);
    check("stall_rdy_back", {31'd0, bus8.in_ready}, 1);
    check("stall_bcd_kept", {20'd0, bus8.out_bcd}, 32'h100);
    check("stall_overrun_sticky", {31'd0, bus8.overrun}, 1);

    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("overrun_clr", {31'd0, bus8.overrun}, 0);

    // Back-to-back: second request lands the cycle after the handoff edge.
    run8("b2b_a", 8'h63, 1'b0, pick(12'h099, 12'hF99), 1'b1);
    run8("b2b_b", 8'hF6, 1'b1, pick(12'h010, 12'hF10), 1'b1);
    check("b2b_overrun", {31'd0, bus8.overrun}, 0);

    // Reset during the third conversion cycle.
    bus8.in_data  = 8'h7F;
    bus8.in_valid = 1'b1;
    tick;
    bus8.in_valid = 1'b0;
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_vld",  {31'd0, bus8.out_valid}, 0);
    check("midrst_bcd",  {20'd0, bus8.out_bcd}, 0);
    check("midrst_sign", {31'd0, bus8.out_sign}, 0);
    check("midrst_rdy",  {31'd0, bus8.in_ready}, 1);
    run8("after_rst", 8'h2A, 1'b0, pick(12'h042, 12'hF42), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
